// File: rtl/serial_out.sv
// 8N1 asynchronous serial transmitter: bytes are queued in a small FIFO and
// shifted out on txd LSB first, each bit held for BAUD_DIV clock cycles.
module serial_out #(
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic [7:0]       data,
  input  logic             port_write,
  output logic             txready,
  output logic             txd,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DivW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DivW-1:0]  DivMax = DivW'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] Full   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stop_end_q, stop_end_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic push, pop, bit_end;

  assign txready = (count_q != Full);
  assign push    = port_write && txready;
  assign bit_end = (div_q == DivMax);

  // FIFO storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge m_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    stop_end_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        div_d = bit_end ? '0 : div_q + DivW'(1);
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        div_d = bit_end ? '0 : div_q + DivW'(1);
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        div_d = bit_end ? '0 : div_q + DivW'(1);
        if (bit_end) begin
          stop_end_d = 1'b1;
          // A queued byte launches straight into its start bit, no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line outputs follow the state one edge later so txd never sees the FIFO.
  always_comb begin
    unique case (state_q)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_q != StIdle);
    done_d = stop_end_q;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stop_end_q <= stop_end_d;
    end
  end

  assign txd   = txd_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_serial_out.sv
// Self-checking bench for serial_out: a frame-timeline model predicts txd, busy,
// done, count and txready after every clock edge.
module tb_serial_out;

  localparam int unsigned B        = 4;
  localparam int unsigned D        = 4;
  localparam int unsigned CW       = 3;
  localparam int          FrameLen = 10 * B;

  logic          m_clock    = 1'b0;
  logic          p_reset    = 1'b1;
  logic          port_write = 1'b0;
  logic [7:0]    data       = 8'h00;
  logic          txready, txd, busy, done;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 m_clock = ~m_clock;

  serial_out #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (D),
    .CNT_W      (CW)
  ) u_dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .data       (data),
    .port_write (port_write),
    .txready    (txready),
    .txd        (txd),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  // Reference: queue of accepted bytes plus the two most recent frames, each
  // described by the edge index at which its start bit appears on the line.
  logic [7:0] q[$];
  int         k;
  bit         cur_v, prev_v;
  int         cur_s, prev_s;
  logic [7:0] cur_b, prev_b;
  int         model_done, dut_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic logic frame_bit(input int s, input logic [7:0] b, input int kk);
    int i;
    i = (kk - s) / B;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    return 1'b1;
  endfunction

  function automatic bit covers(input bit v, input int s, input int kk);
    return v && (kk >= s) && (kk < s + FrameLen);
  endfunction

  task automatic model_clear();
    q.delete();
    cur_v  = 1'b0;
    prev_v = 1'b0;
    cur_s  = 0;
    prev_s = 0;
    k      = 0;
  endtask

  task automatic model_edge(input bit pw, input logic [7:0] d);
    int  cnt;
    bit  do_pop;
    cnt    = q.size();
    do_pop = (cnt != 0) && (!cur_v || (k >= cur_s + FrameLen - 1));
    if (do_pop) begin
      prev_v = cur_v;
      prev_s = cur_s;
      prev_b = cur_b;
      cur_v  = 1'b1;
      cur_s  = k + 1;
      cur_b  = q.pop_front();
    end
    if (pw && (cnt != D)) q.push_back(d);
  endtask

  task automatic expect_outputs();
    logic e_txd, e_busy, e_done;
    e_txd  = 1'b1;
    e_busy = 1'b0;
    if (covers(cur_v, cur_s, k)) begin
      e_txd  = frame_bit(cur_s, cur_b, k);
      e_busy = 1'b1;
    end else if (covers(prev_v, prev_s, k)) begin
      e_txd  = frame_bit(prev_s, prev_b, k);
      e_busy = 1'b1;
    end
    e_done = (cur_v && (k == cur_s + FrameLen)) || (prev_v && (k == prev_s + FrameLen));
    if (e_done) model_done++;
    check_eq("txd", 32'(txd), 32'(e_txd));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("count", 32'(count), 32'(q.size()));
    check_eq("txready", 32'(txready), 32'(q.size() != D));
  endtask

  task automatic tick(input bit pw, input logic [7:0] d);
    port_write = pw;
    data       = d;
    @(posedge m_clock);
    model_edge(pw, d);
    #1;
    expect_outputs();
    if (done) dut_done++;
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_txd"}, 32'(txd), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_count"}, 32'(count), 32'd0);
    check_eq({tag, "_txready"}, 32'(txready), 32'd1);
  endtask

  initial begin
    int guard;
    int base;
    model_clear();
    model_done = 0;
    dut_done   = 0;

    #2 p_reset = 1'b0;
    repeat (2) @(posedge m_clock);
    #1;
    check_reset_state("reset");
    p_reset = 1'b1;
    model_clear();

    // Single 0x55 byte from idle.
    tick(1'b1, 8'h55);
    idle(FrameLen + 8);

    // "AB\n" back to back.
    tick(1'b1, 8'h41);
    tick(1'b1, 8'h42);
    tick(1'b1, 8'h0A);
    idle(3 * FrameLen + 8);

    // Six writes into a depth-4 FIFO: one launches, four queue, last dropped.
    base = dut_done;
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
    idle(5 * FrameLen + 8);
    check_eq("six_writes_done_pulses", 32'(dut_done - base), 32'd5);

    // Push on the same edge as a STOP-end pop with one byte queued.
    tick(1'b1, 8'hC1);
    tick(1'b1, 8'hC2);
    guard = 0;
    while ((k != cur_s + FrameLen - 1) && (guard < 200)) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check_eq("same_edge_reached", 32'(guard < 200), 32'd1);
    tick(1'b1, 8'hC3);
    check_eq("same_edge_count", 32'(count), 32'd1);
    idle(3 * FrameLen + 8);

    // Hold port_write high for 20 cycles against a full FIFO.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
    for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom));
    check_eq("full_hold_count", 32'(count), 32'(D));
    idle(5 * FrameLen + 8);

    // Asynchronous reset in the middle of the data bits of 0xA3.
    tick(1'b1, 8'hA3);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    guard = 0;
    while ((k != cur_s + 3 * B) && (guard < 200)) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check_eq("mid_frame_reached", 32'(guard < 200), 32'd1);
    check_eq("mid_frame_busy", 32'(busy), 32'd1);
    #2 p_reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge m_clock);
    #1;
    check_reset_state("held_reset");
    p_reset = 1'b1;
    model_clear();
    base = dut_done;
    idle(FrameLen + 8);
    check_eq("post_reset_no_done", 32'(dut_done - base), 32'd0);

    // Randomized traffic with occasional bursts.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int j = 0; j < 6; j++) tick(1'b1, 8'($urandom));
      end else begin
        tick($urandom_range(0, 11) == 0, 8'($urandom));
      end
    end
    idle(6 * FrameLen);
    check_eq("total_done_pulses", 32'(dut_done), 32'(model_done));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
